// File: rtl/mdu_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } mdu_state_e;

  // Wide enough to hold the value W itself, not just W-1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/mdu_abs.sv
// Conditional two's-complement negate: y = neg ? -a : a, W bits wide.
module mdu_abs #(
  parameter int unsigned W = 32
) (
  input  logic         neg_i,
  input  logic [W-1:0] a_i,
  output logic [W-1:0] y_o
);

  assign y_o = neg_i ? (~a_i + W'(1)) : a_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 signed/unsigned multiply and restoring divide with HI/LO results.
// Define MDU_HILO_WRITE_EN to add direct hi/lo write ports (MTHI/MTLO).
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = cnt_width(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
`ifdef MDU_HILO_WRITE_EN
  input  logic                  hi_wr,
  input  logic                  lo_wr,
  input  logic [DATA_WIDTH-1:0] wr_data,
`endif
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] Operand1,
  input  logic [DATA_WIDTH-1:0] Operand2,
  output logic                  busy,
  output logic                  done,
  output logic                  div0,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int unsigned W = DATA_WIDTH;

  mdu_state_e           state_q;
  logic                 div_q;
  logic                 dz_q;
  logic                 neg_q;
  logic                 rem_neg_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [2*W-1:0]       acc_q;
  logic [W-1:0]         b_q;
  logic [W-1:0]         hi_q;
  logic [W-1:0]         lo_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 div0_q;

  logic                 in_signed;
  logic                 in_div;
  logic                 in_zero;
  logic                 sign_a;
  logic                 sign_b;
  logic [W-1:0]         mag_a;
  logic [W-1:0]         mag_b;

  assign in_signed = ~op[0];
  assign in_div    = op[1];
  assign in_zero   = (Operand2 == '0);
  assign sign_a    = in_signed & Operand1[W-1];
  assign sign_b    = in_signed & Operand2[W-1];

  mdu_abs #(.W(W)) u_abs_a (
    .neg_i (sign_a),
    .a_i   (Operand1),
    .y_o   (mag_a)
  );

  mdu_abs #(.W(W)) u_abs_b (
    .neg_i (sign_b),
    .a_i   (Operand2),
    .y_o   (mag_b)
  );

  // acc_q: multiply = {partial product, remaining multiplier bits};
  //        divide   = {partial remainder, dividend/quotient bits}.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     div_shift;
  logic [W:0]     div_diff;
  logic [2*W-1:0] div_next;
  logic [2*W-1:0] step_acc;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next  = {mul_sum, acc_q[W-1:1]};
    div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_next  = '0;
    if (div_diff[W]) begin
      div_next = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
    end else begin
      div_next = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
    end
    step_acc = div_q ? div_next : mul_next;
  end

  // Lower half of the 2W negate doubles as the negated quotient.
  logic [2*W-1:0] acc_fix;
  logic [W-1:0]   rem_fix;

  mdu_abs #(.W(2*W)) u_neg_acc (
    .neg_i (neg_q),
    .a_i   (acc_q),
    .y_o   (acc_fix)
  );

  mdu_abs #(.W(W)) u_neg_rem (
    .neg_i (rem_neg_q),
    .a_i   (acc_q[2*W-1:W]),
    .y_o   (rem_fix)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      div_q     <= 1'b0;
      dz_q      <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            div_q     <= in_div;
            dz_q      <= in_div & in_zero;
            neg_q     <= sign_a ^ sign_b;
            rem_neg_q <= sign_a;
            cnt_q     <= CNT_WIDTH'(W);
            // Divide-by-zero returns the raw dividend, so skip the magnitude.
            acc_q     <= {{W{1'b0}}, (in_div & in_zero) ? Operand1 : mag_a};
            b_q       <= mag_b;
            busy_q    <= 1'b1;
            div0_q    <= 1'b0;
            state_q   <= (in_div & in_zero) ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
          acc_q <= step_acc;
          cnt_q <= cnt_q - CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(1)) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          if (dz_q) begin
            hi_q   <= acc_q[W-1:0];
            lo_q   <= '1;
            div0_q <= 1'b1;
          end else if (div_q) begin
            hi_q <= rem_fix;
            lo_q <= acc_fix[W-1:0];
          end else begin
            hi_q <= acc_fix[2*W-1:W];
            lo_q <= acc_fix[W-1:0];
          end
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
`ifdef MDU_HILO_WRITE_EN
      // A write alongside an accepted start lands now; FIX overwrites it later.
      if (!busy_q) begin
        if (hi_wr) hi_q <= wr_data;
        if (lo_wr) lo_q <= wr_data;
      end
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed vectors, monitor checks results on done.
`timescale 1ns/1ps
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] Operand1 = '0;
  logic [31:0] Operand2 = '0;
  logic        busy, done, div0;
  logic [31:0] hi, lo;
`ifdef MDU_HILO_WRITE_EN
  logic        hi_wr = 1'b0;
  logic        lo_wr = 1'b0;
  logic [31:0] wr_data = '0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  always #5 CLK = ~CLK;

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .CLK      (CLK),
    .RST      (RST),
`ifdef MDU_HILO_WRITE_EN
    .hi_wr    (hi_wr),
    .lo_wr    (lo_wr),
    .wr_data  (wr_data),
`endif
    .start    (start),
    .op       (op),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .busy     (busy),
    .done     (done),
    .div0     (div0),
    .hi       (hi),
    .lo       (lo)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: busy cycles since accept equal the latency; results popped on done.
  int bcnt = 0;
  always @(negedge CLK) begin
    if (!RST) begin
      bcnt = 0;
    end else begin
      if (busy) bcnt++;
      if (done) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending op");
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("hi", hi, e.hi);
          chk("lo", lo, e.lo);
          chk("div0", {31'b0, div0}, {31'b0, e.div0});
          chk("latency", bcnt, e.lat);
          chk("busy_with_done", {31'b0, busy}, 32'd1);
        end
        bcnt = 0;
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic ediv0,
                       input int elat, input bit push);
    exp_t e;
    @(negedge CLK);
    start = 1'b1; op = o; Operand1 = a; Operand2 = b;
    if (push) begin
      e.hi = ehi; e.lo = elo; e.div0 = ediv0; e.lat = elat;
      sb_q.push_back(e);
    end
    @(posedge CLK);
    #1 start = 1'b0;
  endtask

  // Waits for done; pa/pb are cycle numbers at which a stray start is driven.
  task automatic wait_done(input int pa, input int pb);
    bit seen;
    seen = 1'b0;
    for (int k = 1; k <= 100 && !seen; k++) begin
      @(negedge CLK);
      if (done) seen = 1'b1;
      start = (k == pa || k == pb);
      if (start) begin
        op = MDU_DIVU; Operand1 = 32'hDEAD0000 + k; Operand2 = 32'h3;
      end
    end
    start = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 100 cycles");
    end
    @(negedge CLK);
    chk("busy_after_done", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    bit seen_done;
    repeat (3) @(negedge CLK);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_div0", {31'b0, div0}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    RST = 1'b1;

    issue(MDU_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34, 1);
    wait_done(0, 0);
    issue(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34, 1);
    wait_done(0, 0);
    issue(MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 1);
    wait_done(0, 0);
    issue(MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34, 1);
    wait_done(0, 0);
    issue(MDU_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 34, 1);
    wait_done(0, 0);
    issue(MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34, 1);
    wait_done(0, 0);
    issue(MDU_MULT,  32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006, 1'b0, 34, 1);
    wait_done(0, 0);

    issue(MDU_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1, 2, 1);
    wait_done(0, 0);
    repeat (3) @(negedge CLK);
    chk("div0_held", {31'b0, div0}, 32'd1);
    chk("hi_held", hi, 32'h00000007);
    chk("lo_held", lo, 32'hFFFFFFFF);

    // Stray starts mid-operation must be ignored; div0 clears on this start.
    issue(MDU_MULT,  32'h00001234, 32'h00000010, 32'h00000000, 32'h00012340, 1'b0, 34, 1);
    wait_done(5, 10);
    repeat (40) @(negedge CLK);
    chk("ignored_start_hi", hi, 32'h00000000);
    chk("ignored_start_lo", lo, 32'h00012340);

    issue(MDU_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 2, 1);
    wait_done(0, 0);
    issue(MDU_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 34, 1);
    wait_done(0, 0);

    // Reset in the middle of a divide: no result, no done.
    issue(MDU_DIV,   32'h00000064, 32'h00000007, 32'h0, 32'h0, 1'b0, 0, 0);
    repeat (19) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 45; k++) begin
      @(negedge CLK);
      if (done) seen_done = 1'b1;
    end
    chk("no_done_after_reset", {31'b0, seen_done}, 32'd0);

`ifdef MDU_HILO_WRITE_EN
    @(negedge CLK);
    hi_wr = 1'b1; wr_data = 32'h12345678;
    @(negedge CLK);
    hi_wr = 1'b0;
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_lo", lo, 32'h00000000);
    issue(MDU_MULTU, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006, 1'b0, 34, 1);
    @(negedge CLK);
    @(negedge CLK);
    lo_wr = 1'b1; wr_data = 32'hDEADBEEF;
    @(negedge CLK);
    lo_wr = 1'b0;
    chk("mtlo_busy_lo", lo, 32'h00000000);
    wait_done(0, 0);
`endif

    issue(MDU_MULTU, 32'h00000009, 32'h00000009, 32'h00000000, 32'h00000051, 1'b0, 34, 1);
    wait_done(0, 0);

    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
